// File: rtl/ram_arb_pkg.sv
// Shared definitions for the dual-requester RAM arbiter: FSM states and
// round-robin pointer reset value.
package ram_arb_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Pointer value names the requester favoured on contention.
   localparam logic RR_PTR_RST = 1'b0;

endpackage

// File: rtl/ram_arb_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, pointer is registered.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   input  logic       hold,
   output logic [1:0] gnt
);

   logic ptr;

   always_comb begin
      gnt = '0;
      if (en) begin
         if (&req) gnt[ptr] = 1'b1;
         else      gnt      = req;
      end
   end

   // A withheld grant keeps favouring its winner so it is served next cycle.
   always_ff @(posedge clk) begin
      if (rst)       ptr <= RR_PTR_RST;
      else if (|gnt) ptr <= hold ? gnt[1] : ~gnt[1];
   end

endmodule

// File: rtl/ram_arb.sv
// Two requesters sharing one RAM through independent write/read round-robin
// arbiters, with an optional zero-fill sweep after reset.
module ram_arb
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8,
   parameter int CLEAR_EN   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  req1_ready,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  clear_busy
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                state;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  busy_q;
   logic                  rsp_vld;
   logic                  rsp_tag;

   logic                  run;
   logic [1:0]            wcand, rcand, wgnt, rgnt;
   logic [ADDR_WIDTH-1:0] wsel_addr, rsel_addr;
   logic [DATA_WIDTH-1:0] wsel_data;
   logic                  hazard, rd_acc;

   assign run   = (state == ST_RUN) && !rst;
   assign wcand = {req1_valid &  req1_we, req0_valid &  req0_we};
   assign rcand = {req1_valid & ~req1_we, req0_valid & ~req0_we};

   rr_arb2 u_wr_arb (
      .clk  (clk),
      .rst  (rst),
      .en   (run),
      .req  (wcand),
      .hold (1'b0),
      .gnt  (wgnt)
   );

   rr_arb2 u_rd_arb (
      .clk  (clk),
      .rst  (rst),
      .en   (run),
      .req  (rcand),
      .hold (hazard),
      .gnt  (rgnt)
   );

   always_comb begin
      wsel_addr = wgnt[1] ? req1_addr  : req0_addr;
      wsel_data = wgnt[1] ? req1_wdata : req0_wdata;
      rsel_addr = rgnt[1] ? req1_addr  : req0_addr;
      hazard    = (|wgnt) && (|rgnt) && (wsel_addr == rsel_addr);
      rd_acc    = (|rgnt) && !hazard;
      req0_ready  = wgnt[0] | (rgnt[0] & ~hazard);
      req1_ready  = wgnt[1] | (rgnt[1] & ~hazard);
      ram_rd_addr = rsel_addr;
      if (state == ST_CLEAR) begin
         ram_wr_en   = !rst;
         ram_wr_addr = clr_addr;
         ram_wr_data = '0;
      end else begin
         ram_wr_en   = |wgnt;
         ram_wr_addr = wsel_addr;
         ram_wr_data = wsel_data;
      end
   end

   assign rsp0_valid = rsp_vld & ~rsp_tag & ~rst;
   assign rsp1_valid = rsp_vld &  rsp_tag & ~rst;
   assign rsp0_rdata = ram_rd_data;
   assign rsp1_rdata = ram_rd_data;
   assign clear_busy = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
         busy_q   <= (CLEAR_EN != 0);
         clr_addr <= '0;
         rsp_vld  <= 1'b0;
         rsp_tag  <= 1'b0;
      end else begin
         rsp_vld <= rd_acc;
         rsp_tag <= rgnt[1];
         case (state)
            ST_CLEAR: begin
               // Hold at the last address so the sweep never wraps to 0.
               if (&clr_addr) begin
                  state  <= ST_RUN;
                  busy_q <= 1'b0;
               end else begin
                  clr_addr <= clr_addr + ADDR_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, giving the RAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the RAM data width.
REQ-003 The block SHALL have parameter CLEAR_EN, default 1; when 1, the block zero-fills the RAM after reset.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Ports reqN_valid, input, 1 (N=0,1): requester N presents a request.
REQ-007 Ports reqN_we, input, 1: 1 = write, 0 = read.
REQ-008 Ports reqN_addr, input, ADDR_WIDTH, and reqN_wdata, input, DATA_WIDTH: request address and write data.
REQ-009 Ports reqN_ready, output, 1: request accepted this cycle when valid and ready are both high.
REQ-010 Ports rspN_valid, output, 1, and rspN_rdata, output, DATA_WIDTH: read response to requester N.
REQ-011 Ports ram_wr_en, output, 1; ram_wr_addr, output, ADDR_WIDTH; ram_wr_data, output, DATA_WIDTH: RAM write port.
REQ-012 Port ram_rd_addr, output, ADDR_WIDTH: RAM read address.
REQ-013 Port ram_rd_data, input, DATA_WIDTH: RAM read data, valid one cycle after the address is sampled.
REQ-014 Port clear_busy, output, 1: high while the zero-fill sweep runs.

Function
REQ-015 The FSM SHALL have states CLEAR and RUN; reset enters CLEAR if CLEAR_EN=1, else RUN.
REQ-016 In CLEAR: ram_wr_en=1, ram_wr_data=0, ram_wr_addr counts 0..2^ADDR_WIDTH-1 one per cycle, then go to RUN; both reqN_ready=0; clear_busy=1.
REQ-017 In RUN: at most one write and one read are granted per cycle, through independent write and read arbiters.
REQ-018 Each arbiter SHALL be round-robin over 2 requesters: when both compete, the requester not granted last wins; the pointer updates only on a grant; a lone requester is always granted.
REQ-019 A requester is a write candidate when valid and we=1, and a read candidate when valid and we=0.
REQ-020 reqN_ready SHALL be combinational in the cycle of the grant; RAM port outputs SHALL be combinational muxes of the granted request.
REQ-021 When no write is granted, ram_wr_en SHALL be 0.
REQ-022 Hazard: if the granted read and the granted write target the same address in the same cycle, the read SHALL be withheld (ready low); the read wins arbitration next cycle and returns the new data.
REQ-023 Read latency: rspN_valid SHALL pulse for exactly 1 cycle, in the cycle after acceptance; rspN_rdata = ram_rd_data in that cycle.
REQ-024 A 1-bit registered tag SHALL route the response; responses stay in acceptance order, one per accepted read.
REQ-025 Requests held valid without ready SHALL remain pending with no loss; back-to-back reads from one requester SHALL sustain 1 per cycle when uncontended.
REQ-026 The clear counter SHALL stop at the final address, with no wrap-around write to address 0.

Reset
REQ-027 On rst: FSM=CLEAR (or RUN per CLEAR_EN); clear counter=0; both RR pointers favour requester 0; rsp valid pipeline=0.
REQ-028 During and after rst: reqN_ready=0, rspN_valid=0, ram_wr_en=0 (except the CLEAR state's writes), clear_busy per REQ-016.
REQ-029 rst asserted mid-sweep or mid-read SHALL restart the sweep and drop any in-flight response.

Structure
REQ-030 The FSM state encoding and the RR-pointer reset value SHALL live in shared package ram_arb_pkg.
REQ-031 One sub-module, rr_arb2, SHALL implement the 2-way round-robin and be instantiated twice (write and read).

Verification
REQ-032 CLEAR_EN=1, ADDR_WIDTH=10: release rst -> clear_busy high exactly 1024 cycles, writes 0 to addresses 0..1023, then ready rises.
REQ-033 Both requesters read continuously -> grants alternate 0,1,0,1; each rsp arrives 1 cycle after its ready with the correct data.
REQ-034 req0 writes 0xA5 to address 0x010 while req1 reads 0x010 in the same cycle -> req1 stalls 1 cycle, then rsp1_rdata=0xA5.
REQ-035 req0 writes 0x3C to address 5 while req1 reads address 6 -> both are granted in the same cycle; rsp1 arrives next cycle.
REQ-036 rst pulse at sweep address 500 -> sweep restarts at 0; no rsp valid; ready stays low until the sweep completes.
REQ-037 Random valid/we/addr traffic against a reference memory model -> zero data mismatches and no lost or duplicated responses.
